// File: rtl/dot_row_acc.sv
// dot_row_acc: accumulates one partial dot product per accepted input beat
// over a per-row number of line pairs, tags each finished row sum with a
// row index and queues it in a small first-word-fall-through output FIFO.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   resetb     asynchronous active-low reset
//   cfg_lines  line pairs per row, sampled on the first beat of a row (0 acts as 1)
//   in_valid   partial product valid
//   in_data    partial dot product of one line pair
//   in_ready   block accepts in_data this cycle
//   out_valid  row result available (FIFO non-empty)
//   out_data   accumulated row sum at FIFO head
//   out_idx    row index at FIFO head
//   out_ready  consumer pops the head when out_valid is high
//   busy       a row is partially accumulated or a push is pending
//   dbg_state  current FSM state (0 IDLE, 1 ACC, 2 PUSH) for observation
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. valid never waits for ready; the producer
// holds its data stable until the transfer happens.
module dot_row_acc #(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int IDX_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [LEN_W-1:0]  cfg_lines,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    input  logic              out_ready,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = IDX_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_PUSH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [IDX_W-1:0]    row_idx_q;

    logic [ENTRY_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_full;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = (state_q == ST_PUSH);
    assign pop       = (count_q != '0) && out_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A one-line row (cfg_lines 0 or 1) is complete on its first beat.
                if (accept) begin
                    state_d = (cfg_lines <= LEN_W'(1)) ? ST_PUSH : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept && (rem_q == LEN_W'(1))) begin
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Blocking input during PUSH and while full guarantees the FIFO always
    // has a free slot when PUSH writes. Gated by resetb so the producer sees
    // no ready while reset is held.
    always_comb begin
        in_ready  = resetb && (state_q != ST_PUSH) && !fifo_full;
        busy      = (state_q != ST_IDLE);
        dbg_state = state_q;
    end

    // ---------------- Accumulator and line counter ----------------
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d = in_data;
                    rem_d = (cfg_lines == '0) ? '0 : cfg_lines - LEN_W'(1);
                end
            end
            ST_ACC: begin
                if (accept) begin
                    acc_d = acc_q + in_data;  // modulo 2^DATA_W, carry dropped
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            ST_PUSH: acc_d = '0;
            default: begin
                acc_d = '0;
                rem_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            acc_q     <= '0;
            rem_q     <= '0;
            row_idx_q <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            if (push) begin
                row_idx_q <= row_idx_q + IDX_W'(1);  // wraps naturally
            end
        end
    end

    // ---------------- Output FIFO ----------------
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {row_idx_q, acc_q};
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Head is read straight from the storage registers (fall-through), so it
    // stays stable while stalled.
    assign out_valid = (count_q != '0);
    assign out_data  = fifo_q[rd_ptr_q][DATA_W-1:0];
    assign out_idx   = fifo_q[rd_ptr_q][ENTRY_W-1:DATA_W];

endmodule

// File: tb/tb_dot_row_acc.sv
module tb_dot_row_acc;

  localparam int DATA_W     = 32;
  localparam int LEN_W      = 16;
  localparam int IDX_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int W          = IDX_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic [LEN_W-1:0]  cfg_lines = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_ready = 1'b0;
  logic              busy;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  dot_row_acc #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .resetb(resetb), .cfg_lines(cfg_lines),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0]     exp_q[$];
  logic [IDX_W-1:0] model_idx = '0;
  logic             rand_ready = 1'b0;
  logic             ready_fixed = 1'b0;

  // out_ready has a single driver: fixed level or random toggling.
  always begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (resetb && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got idx %0d data 0x%0h expected no result", out_idx, out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_idx", 64'(out_idx), 64'(e[W-1:DATA_W]));
        check("sb_data", 64'(out_data), 64'(e[DATA_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at posedge+1 of the cycle after the beat was accepted.
  task automatic send_beat(input logic [DATA_W-1:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: got in_ready 0 for 200 cycles expected 1");
      in_valid = 1'b0;
    end else begin
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      step();
      t++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [LEN_W-1:0]  cfg;
    int                n;
    logic [DATA_W-1:0] d [4];
    logic [DATA_W-1:0] sum;
  } vec_t;

  vec_t tbl [8];
  int   nv = 0;

  task automatic add_vec(input logic [LEN_W-1:0] cfg, input int n,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3,
                         input logic [DATA_W-1:0] sum);
    tbl[nv].cfg  = cfg;
    tbl[nv].n    = n;
    tbl[nv].d[0] = d0;
    tbl[nv].d[1] = d1;
    tbl[nv].d[2] = d2;
    tbl[nv].d[3] = d3;
    tbl[nv].sum  = sum;
    nv++;
  endtask

  // ---------------- global bound ----------------
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "simulation bound expired");
  end

  // ---------------- main test ----------------
  initial begin
    logic [IDX_W-1:0]  first_idx;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] d;

    add_vec(16'd4, 4, 32'd10, 32'd20, 32'd30, 32'd40, 32'd100);
    add_vec(16'd2, 2, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'h0000_0001);
    add_vec(16'd2, 2, 32'd5, 32'd6, 32'd0, 32'd0, 32'd11);
    add_vec(16'd1, 1, 32'd7, 32'd0, 32'd0, 32'd0, 32'd7);
    add_vec(16'd0, 1, 32'd9, 32'd0, 32'd0, 32'd0, 32'd9);
    add_vec(16'd3, 3, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd0, 32'd5);

    // Reset state.
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    repeat (3) step();
    resetb = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_state", 64'(dbg_state), 64'd0);
    check("rel_out_valid", 64'(out_valid), 64'd0);

    // Directed rows: result latency and the single-cycle PUSH bubble.
    ready_fixed = 1'b1;
    step();
    for (int v = 0; v < nv; v++) begin
      cfg_lines = tbl[v].cfg;
      exp_q.push_back({model_idx, tbl[v].sum});
      model_idx++;
      for (int b = 0; b < tbl[v].n; b++) begin
        send_beat(tbl[v].d[b]);
        if (b == 0) cfg_lines = 16'hBEEF;  // must not affect this row
      end
      check("push_in_ready", 64'(in_ready), 64'd0);
      check("push_busy", 64'(busy), 64'd1);
      check("push_out_valid", 64'(out_valid), 64'd0);
      step();
      check("post_in_ready", 64'(in_ready), 64'd1);
      check("post_busy", 64'(busy), 64'd0);
      check("post_out_valid", 64'(out_valid), 64'd1);
      check("post_out_data", 64'(out_data), 64'(tbl[v].sum));
    end
    wait_drain("drain_table", 50);

    // FIFO fills while stalled, head holds, then drains in order.
    ready_fixed = 1'b0;
    step();
    step();
    cfg_lines = 16'd1;
    first_idx = model_idx;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back({model_idx, 32'(200 + k)});
      model_idx++;
    end
    for (int k = 0; k < 4; k++) send_beat(32'(200 + k));
    step();
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("stall_head_idx", 64'(out_idx), 64'(first_idx));
      check("stall_head_data", 64'(out_data), 64'd200);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    ready_fixed = 1'b1;
    send_beat(32'd204);
    send_beat(32'd205);
    wait_drain("drain_full", 50);

    // Random gaps and back-pressure against a plain modulo-sum model.
    rand_ready = 1'b1;
    for (int r = 0; r < 100; r++) begin
      cfg_lines = 16'd3;
      sum = '0;
      for (int b = 0; b < 3; b++) begin
        repeat ($urandom_range(0, 2)) step();
        d = $urandom;
        sum = sum + d;
        send_beat(d);
        if (b == 0) cfg_lines = 16'($urandom_range(0, 7));
      end
      exp_q.push_back({model_idx, sum});
      model_idx++;
    end
    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    wait_drain("drain_random", 100);

    // Reset mid-row with results queued.
    ready_fixed = 1'b0;
    step();
    step();
    cfg_lines = 16'd1;
    send_beat(32'd50);
    send_beat(32'd60);
    cfg_lines = 16'd4;
    send_beat(32'd1);
    send_beat(32'd1);
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2;
    resetb = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    step();
    step();
    resetb = 1'b1;
    model_idx = '0;
    ready_fixed = 1'b1;
    step();
    cfg_lines = 16'd4;
    exp_q.push_back({model_idx, 32'd4});
    model_idx++;
    for (int b = 0; b < 4; b++) send_beat(32'd1);
    wait_drain("drain_after_reset", 20);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dot_row_acc.md
Name: dot_row_acc

Overview:
- Downstream consumer of the 16-lane 32-bit dot-product stage.
- Accumulates one 32-bit partial dot product per 512-bit line pair over a configurable number of line pairs to form one matrix-row result.
- Tags each row result with a row index and buffers it in a small output FIFO for the write-back path.
- Decouples the combinational dot-product datapath from write-back stalls using valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32, width of partial and accumulated results.
- LEN_W, 16, width of the lines-per-row configuration and line counter.
- IDX_W, 16, width of the row index tag.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- resetb  input  1  asynchronous active-low reset.
- cfg_lines  input  LEN_W  line pairs per row; sampled on the first beat of each row.
- in_valid  input  1  partial product valid.
- in_data  input  DATA_W  partial dot product of one line pair.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  row result available (FIFO non-empty).
- out_data  output  DATA_W  accumulated row sum at FIFO head.
- out_idx  output  IDX_W  row index at FIFO head.
- out_ready  input  1  consumer pops the head when out_valid is high.
- busy  output  1  a row is partially accumulated or a push is pending.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (resetb); all registers clear on assertion.
- Reset values:
  - in_ready=0 while resetb is low, then 1 from the first cycle after release (FIFO empty).
  - out_valid=0, out_data=0, out_idx=0, busy=0.
  - Accumulator=0, line counter=0, row index=0, FIFO empty, state=IDLE.
- Handshakes:
  - Input beat accepted when in_valid and in_ready are both high.
  - Output pop occurs when out_valid and out_ready are both high.
  - in_valid may assert independent of in_ready; the producer holds in_data until accepted.
- in_ready = (state != PUSH) and (FIFO not full). This guarantees a slot exists when PUSH writes.
- States:
  - IDLE:
    - On accept: acc <= in_data; remaining <= max(cfg_lines,1) - 1.
    - If remaining would be 0, go to PUSH; else go to ACC.
  - ACC:
    - On accept: acc <= acc + in_data; remaining decrements.
    - When the accepted beat has remaining==1, go to PUSH. No accept: hold.
  - PUSH (exactly one cycle):
    - Write {row_idx, acc} to the FIFO tail and increment row_idx.
    - Clear acc; go to IDLE. No input accepted in this cycle.
- Arithmetic:
  - Sums are modulo 2^DATA_W; carries are discarded with no saturation.
  - row_idx wraps from 2^IDX_W-1 to 0.
- cfg_lines==0 is treated as 1. cfg_lines changing mid-row has no effect until the next row's first beat.
- Latency:
  - Final beat accepted in cycle T; FIFO written at the end of T+1 (PUSH).
  - out_valid rises in T+2 when the FIFO was empty.
  - Minimum input throughput: N beats per N+1 cycles.
- FIFO behaviour:
  - First-word-fall-through: out_data and out_idx are registered FIFO head outputs, stable while out_valid=1 and out_ready=0.
  - A simultaneous push and pop with the FIFO full is legal; count stays at FIFO_DEPTH.
  - Pop from empty is ignored.
- busy = (state != IDLE).
- Reset mid-row or with a non-empty FIFO discards all partial sums and buffered results; row_idx restarts at 0.

Test Plan:
1. cfg_lines=4; in_data 10,20,30,40 back-to-back; out_ready=1 -> one result out_data=100, out_idx=0; out_valid first high 2 cycles after the fourth accept; in_ready low exactly 1 cycle (PUSH).
2. cfg_lines=2; rows {0xFFFFFFFF,2} then {5,6} -> out_data 0x00000001 idx0, then 11 idx1 (wrap-around sum, index increments).
3. cfg_lines=1, then cfg_lines=0; in_data 7 then 9 -> two results 7 idx0 and 9 idx1; each row takes 2 cycles.
4. out_ready=0; cfg_lines=1; stream 6 rows -> FIFO holds 4; in_ready drops after the 4th push. Raise out_ready -> results pop in order idx0..idx5 with no loss; head stays stable while stalled.
5. Random in_valid gaps and out_ready toggling over 100 rows of cfg_lines=3 -> every out_data equals the modulo-2^32 golden sum; out_idx is sequential.
6. Assert resetb low after 2 of 4 beats with 2 results queued -> out_valid=0 and busy=0 immediately. After release, a fresh row of 1,1,1,1 gives 4 with idx0.
